// File: rtl/adc_request_arbiter.sv
// rtl/adc_request_arbiter.sv - round-robin arbiter sharing one MCP3202 ADC over SPI
// One frame per grant: CS low, setup, 17 SCK periods, result + done pulse, CS-high hold.
module adc_request_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int SCK_DIV        = 150,
    parameter int SETUP_CYCLES   = 14,
    parameter int CS_HIGH_CYCLES = 68
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] req_chan,
    input  logic [NUM_REQ-1:0] req_diff,
    output logic [NUM_REQ-1:0] gnt,
    output logic [NUM_REQ-1:0] done,
    output logic [11:0]        o_data,
    output logic               busy,
    output logic               spi_cs_n,
    output logic               spi_sck,
    output logic               spi_mosi,
    input  logic               spi_miso
);
    localparam int HALF     = SCK_DIV / 2;
    localparam int PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PH_W     = $clog2(SCK_DIV);
    localparam int CNT_MAX  = (SETUP_CYCLES > CS_HIGH_CYCLES) ? SETUP_CYCLES : CS_HIGH_CYCLES;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int NUM_BITS = 17;

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t             state_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   owner_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [PH_W-1:0]    ph_q;
    logic [4:0]         bit_q;
    logic               chan_q;
    logic               diff_q;
    logic [11:0]        shift_q;
    logic [11:0]        data_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [NUM_REQ-1:0] done_q;
    logic               busy_q;
    logic               cs_n_q;
    logic               sck_q;
    logic               mosi_q;

    logic               grant_vld_d;
    logic [PTR_W-1:0]   grant_idx_d;
    logic [PTR_W-1:0]   ptr_d;
    logic               mosi_d;
    int                 scan_idx;

    // Scan from the highest offset down so the lowest offset from the pointer wins.
    always_comb begin
        grant_vld_d = 1'b0;
        grant_idx_d = '0;
        scan_idx    = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            scan_idx = int'(ptr_q) + i;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            if (req[PTR_W'(scan_idx)]) begin
                grant_vld_d = 1'b1;
                grant_idx_d = PTR_W'(scan_idx);
            end
        end
        ptr_d = (int'(grant_idx_d) == NUM_REQ - 1) ? '0 : grant_idx_d + PTR_W'(1);
    end

    // Command bit for the period that follows bit_q: SGL, ODD, MSBF, then zeros.
    always_comb begin
        case (bit_q)
            5'd1:    mosi_d = ~diff_q;
            5'd2:    mosi_d = chan_q;
            5'd3:    mosi_d = 1'b1;
            default: mosi_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            ph_q    <= '0;
            bit_q   <= 5'd0;
            chan_q  <= 1'b0;
            diff_q  <= 1'b0;
            shift_q <= '0;
            data_q  <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
        end else begin
            gnt_q  <= '0;
            done_q <= '0;
            case (state_q)
                IDLE: begin
                    if (grant_vld_d) begin
                        gnt_q   <= NUM_REQ'(1) << grant_idx_d;
                        owner_q <= grant_idx_d;
                        chan_q  <= req_chan[grant_idx_d];
                        diff_q  <= req_diff[grant_idx_d];
                        ptr_q   <= ptr_d;
                        busy_q  <= 1'b1;
                        cs_n_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_q == CNT_W'(SETUP_CYCLES)) begin
                        state_q <= SHIFT;
                        ph_q    <= '0;
                        bit_q   <= 5'd1;
                        mosi_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                SHIFT: begin
                    if (ph_q == PH_W'(SCK_DIV - 1)) begin
                        ph_q  <= '0;
                        sck_q <= 1'b0;
                        if (bit_q == 5'(NUM_BITS)) begin
                            data_q  <= shift_q;
                            done_q  <= NUM_REQ'(1) << owner_q;
                            cs_n_q  <= 1'b1;
                            mosi_q  <= 1'b0;
                            cnt_q   <= '0;
                            state_q <= HOLD;
                        end else begin
                            bit_q  <= bit_q + 5'd1;
                            mosi_q <= mosi_d;
                        end
                    end else begin
                        ph_q <= ph_q + PH_W'(1);
                        if (ph_q == PH_W'(HALF - 1)) begin
                            sck_q <= 1'b1;
                            // Period 5 carries the null bit; periods 6..17 carry B11..B0.
                            if (bit_q >= 5'd6) begin
                                shift_q <= {shift_q[10:0], spi_miso};
                            end
                        end
                    end
                end
                HOLD: begin
                    if (cnt_q == CNT_W'(CS_HIGH_CYCLES - 1)) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign o_data   = data_q;
    assign busy     = busy_q;
    assign spi_cs_n = cs_n_q;
    assign spi_sck  = sck_q;
    assign spi_mosi = mosi_q;
endmodule

// File: tb/tb_adc_request_arbiter.sv
// tb/tb_adc_request_arbiter.sv - scoreboard bench for adc_request_arbiter with an MCP3202 model
module tb_adc_request_arbiter;
    localparam int LAT = 14 + 17 * 150 + 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req = '0;
    logic [1:0]  req_chan = '0;
    logic [1:0]  req_diff = '0;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic [11:0] o_data;
    logic        busy;
    logic        spi_cs_n;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_miso = 1'b0;

    adc_request_arbiter dut (
        .clk(clk), .reset(reset), .req(req), .req_chan(req_chan), .req_diff(req_diff),
        .gnt(gnt), .done(done), .o_data(o_data), .busy(busy),
        .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          idx;
        logic [11:0] data;
        logic [3:0]  mosi;
        int          gcyc;
    } exp_t;

    exp_t pend_q[$];
    exp_t fly_q[$];

    logic [11:0] word_by_ch [2];
    logic        null_val = 1'b0;

    logic        prev_sck = 1'b0;
    logic        prev_cs = 1'b1;
    logic        prev_busy = 1'b0;
    logic        prev_mosi = 1'b0;
    logic        in_frame = 1'b0;
    logic        model_odd = 1'b0;
    logic [3:0]  mosi_bits = '0;
    logic [11:0] w;
    bit          timing_ok = 1'b1;
    int          rises = 0;
    int          low_run = 0;
    int          high_run = 0;
    int          last_rise_cs = -1;
    int          p;

    // Monitor, scoreboard and ADC model; ADC shifts Dout on falling SCK.
    always @(negedge clk) begin
        if (reset) begin
            in_frame  = 1'b0;
            fly_q.delete();
            spi_miso  = 1'b0;
            prev_cs   = 1'b1;
            prev_sck  = 1'b0;
            prev_busy = 1'b0;
        end else begin
            if (gnt != 2'b00) begin
                if (pend_q.size() == 0) begin
                    check(1'b0, "gnt_unexpected", int'(gnt), 0);
                end else begin
                    exp_t e;
                    e = pend_q.pop_front();
                    check(gnt == 2'(1 << e.idx), "gnt_idx", int'(gnt), 1 << e.idx);
                    check(!prev_busy, "gnt_while_busy", int'(prev_busy), 0);
                    e.gcyc = cyc;
                    fly_q.push_back(e);
                end
            end
            if (done != 2'b00) begin
                if (fly_q.size() == 0) begin
                    check(1'b0, "done_unexpected", int'(done), 0);
                end else begin
                    exp_t e;
                    e = fly_q.pop_front();
                    check(done == 2'(1 << e.idx), "done_idx", int'(done), 1 << e.idx);
                    check(o_data == e.data, "o_data", int'(o_data), int'(e.data));
                    check(cyc - e.gcyc == LAT, "latency", cyc - e.gcyc, LAT);
                    check(mosi_bits == e.mosi, "mosi_cmd", int'(mosi_bits), int'(e.mosi));
                    check(rises == 17, "sck_periods", rises, 17);
                    check(timing_ok, "sck_timing", int'(timing_ok), 1);
                end
            end
            if (!spi_cs_n && prev_cs) begin
                if (last_rise_cs >= 0) begin
                    check(cyc - last_rise_cs >= 68, "cs_gap", cyc - last_rise_cs, 68);
                end
                in_frame  = 1'b1;
                rises     = 0;
                low_run   = 1;
                high_run  = 0;
                timing_ok = 1'b1;
                mosi_bits = '0;
            end else if (spi_cs_n && !prev_cs) begin
                in_frame     = 1'b0;
                last_rise_cs = cyc;
                spi_miso     = 1'b0;
            end else if (in_frame) begin
                if (spi_sck && !prev_sck) begin
                    rises++;
                    if (rises == 1) begin
                        if (low_run < 89) timing_ok = 1'b0;
                    end else if (low_run != 75) begin
                        timing_ok = 1'b0;
                    end
                    if (rises <= 4) mosi_bits = {mosi_bits[2:0], spi_mosi};
                    if (rises == 3) model_odd = spi_mosi;
                    high_run = 1;
                end else if (!spi_sck && prev_sck) begin
                    if (high_run != 75) timing_ok = 1'b0;
                    low_run = 1;
                    p = rises + 1;
                    w = word_by_ch[model_odd];
                    if (p == 5) spi_miso = null_val;
                    else if (p >= 6 && p <= 17) spi_miso = w[17 - p];
                    else spi_miso = 1'b0;
                end else if (spi_sck) begin
                    high_run++;
                    if (spi_mosi != prev_mosi) timing_ok = 1'b0;
                end else begin
                    low_run++;
                end
            end
            prev_cs   = spi_cs_n;
            prev_sck  = spi_sck;
            prev_busy = busy;
            prev_mosi = spi_mosi;
        end
    end

    int model_ptr = 0;

    function automatic int rr_pick(input logic [1:0] m, input int ptr);
        if (m[ptr]) return ptr;
        return 1 - ptr;
    endfunction

    task automatic push_exp(input int k);
        exp_t e;
        e.idx  = k;
        e.data = word_by_ch[req_chan[k]];
        e.mosi = {1'b1, ~req_diff[k], req_chan[k], 1'b1};
        e.gcyc = 0;
        pend_q.push_back(e);
        model_ptr = (k + 1) % 2;
    endtask

    task automatic wait_gnt();
        bit seen = 1'b0;
        for (int i = 0; i < 6000 && !seen; i++) begin
            @(negedge clk);
            if (gnt != 2'b00) seen = 1'b1;
        end
        if (!seen) check(1'b0, "gnt_timeout", 0, 1);
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (done != 2'b00) seen = 1'b1;
        end
        if (!seen) check(1'b0, "done_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (!busy) seen = 1'b1;
        end
        if (!seen) check(1'b0, "idle_timeout", 0, 1);
    endtask

    task automatic wait_rises(input int n);
        bit seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (rises >= n) seen = 1'b1;
        end
        if (!seen) check(1'b0, "rise_timeout", rises, n);
    endtask

    typedef struct {
        logic [1:0]  rq;
        logic [1:0]  chan;
        logic [1:0]  diff;
        logic [11:0] w0;
        logic [11:0] w1;
        logic        nul;
        int          n;
    } vec_t;

    vec_t vecs [6];
    bit   saw_done;

    initial begin
        vecs[0] = '{2'b01, 2'b00, 2'b00, 12'hA5C, 12'h000, 1'b0, 1};
        vecs[1] = '{2'b10, 2'b10, 2'b10, 12'h000, 12'h3FF, 1'b0, 1};
        vecs[2] = '{2'b11, 2'b10, 2'b00, 12'h123, 12'hABC, 1'b0, 4};
        vecs[3] = '{2'b01, 2'b01, 2'b01, 12'h111, 12'h800, 1'b1, 1};
        vecs[4] = '{2'b01, 2'b00, 2'b00, 12'h000, 12'hFFF, 1'b1, 1};
        vecs[5] = '{2'b10, 2'b00, 2'b10, 12'h001, 12'hFFE, 1'b0, 1};
        word_by_ch[0] = '0;
        word_by_ch[1] = '0;

        repeat (3) @(negedge clk);
        check({spi_cs_n, spi_sck, spi_mosi, busy} == 4'b1000, "reset_spi", int'({spi_cs_n, spi_sck, spi_mosi, busy}), 8);
        check({gnt, done} == 4'b0000, "reset_gnt_done", int'({gnt, done}), 0);
        check(o_data == 12'h000, "reset_data", int'(o_data), 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check(spi_cs_n && !busy, "idle_no_req", int'({spi_cs_n, busy}), 2);

        for (int v = 0; v < 6; v++) begin
            word_by_ch[0] = vecs[v].w0;
            word_by_ch[1] = vecs[v].w1;
            null_val      = vecs[v].nul;
            req_chan      = vecs[v].chan;
            req_diff      = vecs[v].diff;
            for (int g = 0; g < vecs[v].n; g++) push_exp(rr_pick(vecs[v].rq, model_ptr));
            req = vecs[v].rq;
            for (int g = 0; g < vecs[v].n; g++) begin
                wait_gnt();
                if (g == vecs[v].n - 1) req = 2'b00;
            end
            wait_done();
            wait_idle();
        end

        // Late request from requester 1 and post-grant changes to requester 0's selects
        word_by_ch[0] = 12'h5A5;
        word_by_ch[1] = 12'h0F0;
        null_val      = 1'b0;
        req_chan      = 2'b00;
        req_diff      = 2'b00;
        push_exp(rr_pick(2'b01, model_ptr));
        req = 2'b01;
        wait_gnt();
        req = 2'b00;
        req_chan[0] = 1'b1;
        req_diff[0] = 1'b1;
        wait_rises(6);
        req_chan[1] = 1'b1;
        req_diff[1] = 1'b0;
        push_exp(1);
        req[1] = 1'b1;
        wait_gnt();
        check(cyc - last_rise_cs >= 68, "late_gnt_gap", cyc - last_rise_cs, 68);
        req = 2'b00;
        wait_done();
        wait_idle();

        // Reset in the middle of SCK period 9
        word_by_ch[0] = 12'h777;
        word_by_ch[1] = 12'h6B3;
        req_chan = 2'b00;
        req_diff = 2'b00;
        push_exp(rr_pick(2'b01, model_ptr));
        req = 2'b01;
        wait_gnt();
        req = 2'b00;
        wait_rises(9);
        #2;
        reset = 1'b1;
        #1;
        check(spi_cs_n == 1'b1, "rst_async_cs", int'(spi_cs_n), 1);
        check(spi_sck == 1'b0, "rst_async_sck", int'(spi_sck), 0);
        check(o_data == 12'h000, "rst_data", int'(o_data), 0);
        check(busy == 1'b0, "rst_busy", int'(busy), 0);
        pend_q.delete();
        model_ptr = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        saw_done = 1'b0;
        repeat (1500) begin
            @(negedge clk);
            if (done != 2'b00) saw_done = 1'b1;
        end
        check(!saw_done, "no_done_after_reset", int'(saw_done), 0);
        req_chan[0] = 1'b1;
        push_exp(rr_pick(2'b01, model_ptr));
        req = 2'b01;
        wait_gnt();
        req = 2'b00;
        wait_done();
        wait_idle();
        check(o_data == 12'h6B3, "post_reset_hold", int'(o_data), 12'h6B3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
